// File: rtl/wptr_sync_gray_if.sv
// Signal bundle between the write-side FIFO logic and the write-domain pointer synchronizer.
interface wptr_sync_gray_if #(
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] rptr_gray_async;
    logic [ADDR_WIDTH-1:0] wptr;
    logic                  gray_err_clr;
    logic [ADDR_WIDTH-1:0] wptr_gray;
    logic [ADDR_WIDTH-1:0] rptr_sync;
    logic [ADDR_WIDTH-1:0] wfree;
    logic                  walmost_full;
    logic                  gray_err;

    modport master (
        output rptr_gray_async, wptr, gray_err_clr,
        input  wptr_gray, rptr_sync, wfree, walmost_full, gray_err
    );

    modport slave (
        input  rptr_gray_async, wptr, gray_err_clr,
        output wptr_gray, rptr_sync, wfree, walmost_full, gray_err
    );
endinterface

// File: rtl/wptr_sync_gray.sv
// Write-domain side of the async FIFO pointer crossing: synchronizes the Gray read pointer,
// exports the Gray write pointer, and derives free-space, almost-full and a CDC integrity flag.
module wptr_sync_gray #(
    parameter int ADDR_WIDTH  = 9,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 4
) (
    input logic              wclk,
    input logic              wrst_n,
    wptr_sync_gray_if.slave  bus
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_V = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] AF_V    = ADDR_WIDTH'(AF_THRESH);
    localparam int WU_W = $clog2(SYNC_STAGES + 2);
    localparam logic [WU_W-1:0] WU_MAX = WU_W'(SYNC_STAGES + 1);

    function automatic logic [ADDR_WIDTH-1:0] gray2bin(input logic [ADDR_WIDTH-1:0] g);
        logic [ADDR_WIDTH-1:0] b;
        b[ADDR_WIDTH-1] = g[ADDR_WIDTH-1];
        for (int i = ADDR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set: a legal Gray step flips at most one bit.
    function automatic logic multi_bit(input logic [ADDR_WIDTH-1:0] x);
        return (x & (x - ADDR_WIDTH'(1))) != '0;
    endfunction

    logic [ADDR_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH-1:0] s_last;
    logic [ADDR_WIDTH-1:0] s_prev;
    logic [WU_W-1:0]       wu_cnt;

    logic [ADDR_WIDTH-1:0] occ;
    logic [ADDR_WIDTH-1:0] rptr_bin;
    logic [ADDR_WIDTH-1:0] wfree_nxt;
    logic                  occ_bad;
    logic                  step_bad;
    logic                  err_set;

    assign s_last = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: plain flop-to-flop, nothing in between.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        rptr_bin  = gray2bin(s_last);
        occ       = bus.wptr - bus.rptr_sync;
        occ_bad   = occ > DEPTH_V;
        wfree_nxt = occ_bad ? '0 : (DEPTH_V - occ);
        step_bad  = multi_bit(s_last ^ s_prev);
        err_set   = (wu_cnt == WU_MAX) && (occ_bad || step_bad);
    end

    // Registered outputs; the error check stays masked until the chain has flushed post-reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            s_prev           <= '0;
            wu_cnt           <= '0;
            bus.wptr_gray    <= '0;
            bus.rptr_sync    <= '0;
            bus.wfree        <= DEPTH_V;
            bus.walmost_full <= 1'b0;
            bus.gray_err     <= 1'b0;
        end else begin
            s_prev           <= s_last;
            if (wu_cnt != WU_MAX) begin
                wu_cnt <= wu_cnt + WU_W'(1);
            end
            bus.wptr_gray    <= bus.wptr ^ (bus.wptr >> 1);
            bus.rptr_sync    <= rptr_bin;
            bus.wfree        <= wfree_nxt;
            bus.walmost_full <= (wfree_nxt <= AF_V);
            if (err_set) begin
                bus.gray_err <= 1'b1;
            end else if (bus.gray_err_clr) begin
                bus.gray_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wptr_sync_gray.sv
// Scoreboard bench for wptr_sync_gray: directed stimulus queues expected outputs, a negedge monitor checks them.
module tb_wptr_sync_gray;
    localparam logic [4:0] M_WG = 5'b00001;
    localparam logic [4:0] M_RS = 5'b00010;
    localparam logic [4:0] M_WF = 5'b00100;
    localparam logic [4:0] M_AF = 5'b01000;
    localparam logic [4:0] M_ER = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct {
        string      name;
        int         due;
        logic [4:0] mask;
        int         wg;
        int         rs;
        int         wf;
        int         af;
        int         er;
    } exp_t;

    logic wclk;
    logic wrst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t cur;

    wptr_sync_gray_if #(.ADDR_WIDTH(9)) bus ();

    wptr_sync_gray #(
        .ADDR_WIDTH (9),
        .SYNC_STAGES(2),
        .AF_THRESH  (4)
    ) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .bus   (bus)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    always @(posedge wclk) cyc <= cyc + 1;

    initial begin
        #20000;
        $display("FAIL watchdog: got time-out, required run to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input string fld, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s.%s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     nm, fld, act, act, req, req, cyc);
        end
    endtask

    // Monitor: pops every expectation that falls due on this cycle.
    always @(negedge wclk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            cur = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s.stale: got no check at cycle %0d, required check at cycle %0d",
                     cur.name, cyc, cur.due);
        end
        while (q.size() > 0 && q[0].due == cyc) begin
            cur = q.pop_front();
            if (cur.mask[0]) chk(cur.name, "wptr_gray",    int'(bus.wptr_gray),    cur.wg);
            if (cur.mask[1]) chk(cur.name, "rptr_sync",    int'(bus.rptr_sync),    cur.rs);
            if (cur.mask[2]) chk(cur.name, "wfree",        int'(bus.wfree),        cur.wf);
            if (cur.mask[3]) chk(cur.name, "walmost_full", int'(bus.walmost_full), cur.af);
            if (cur.mask[4]) chk(cur.name, "gray_err",     int'(bus.gray_err),     cur.er);
        end
    end

    task automatic push(input string nm, input int lat, input logic [4:0] m,
                        input int wg, input int rs, input int wf, input int af, input int er);
        exp_t e;
        e.name = nm;
        e.due  = cyc + lat;
        e.mask = m;
        e.wg   = wg;
        e.rs   = rs;
        e.wf   = wf;
        e.af   = af;
        e.er   = er;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    int g_step [3] = '{1, 3, 2};
    int b_step [3] = '{1, 2, 3};

    initial begin
        int prev_b;
        wrst_n = 1'b0;
        bus.rptr_gray_async = '0;
        bus.wptr = '0;
        bus.gray_err_clr = 1'b0;

        // Reset values.
        tick(2);
        push("rst_init", 0, M_ALL, 0, 0, 256, 0, 0);
        tick(1);
        wrst_n = 1'b1;
        tick(6);

        // Write Gray and free count.
        bus.wptr = 9'd5;
        push("wg5", 1, M_WG, 7, 0, 0, 0, 0);
        push("wf5", 2, M_WF | M_AF | M_ER, 0, 0, 251, 0, 0);
        tick(3);

        // Sync latency through adjacent Gray steps.
        prev_b = 0;
        for (int i = 0; i < 3; i++) begin
            bus.rptr_gray_async = 9'(g_step[i]);
            push($sformatf("sync%0d_old", i), 2, M_RS, 0, prev_b, 0, 0, 0);
            push($sformatf("sync%0d_new", i), 3, M_RS, 0, b_step[i], 0, 0, 0);
            push($sformatf("sync%0d_wf", i),  4, M_WF | M_AF, 0, 0, 256 - (5 - b_step[i]), 0, 0);
            push($sformatf("sync%0d_err", i), 5, M_ER, 0, 0, 0, 0, 0);
            prev_b = b_step[i];
            tick(6);
        end

        // Full boundary with rptr_sync back at 0.
        bus.rptr_gray_async = 9'h000;
        tick(6);
        bus.wptr = 9'h100;
        push("full256", 1, M_WG | M_WF | M_AF | M_ER, 'h180, 0, 0, 1, 0);
        tick(3);
        bus.wptr = 9'd252;
        push("full252", 1, M_WG | M_WF | M_AF | M_ER, 'h082, 0, 4, 1, 0);
        tick(3);
        bus.wptr = 9'd251;
        push("full251", 1, M_WG | M_WF | M_AF | M_ER, 'h086, 0, 5, 0, 0);
        tick(3);

        // Non-adjacent Gray jump sets the sticky error.
        bus.rptr_gray_async = 9'h003;
        push("jump_pre",  2, M_ER, 0, 0, 0, 0, 0);
        push("jump_set",  3, M_RS | M_ER, 0, 2, 0, 0, 1);
        push("jump_hold", 6, M_ER, 0, 0, 0, 0, 1);
        tick(7);
        bus.gray_err_clr = 1'b1;
        push("clr", 1, M_ER, 0, 0, 0, 0, 0);
        tick(1);
        bus.gray_err_clr = 1'b0;
        tick(2);

        // Occupancy beyond DEPTH, with clear held against the error.
        bus.rptr_gray_async = 9'h001;
        push("r1_sync", 3, M_RS, 0, 1, 0, 0, 0);
        push("r1_wf",   5, M_WF | M_AF | M_ER, 0, 0, 6, 0, 0);
        tick(6);
        bus.wptr = 9'd0;
        push("occ_err", 1, M_WF | M_AF | M_ER, 0, 0, 0, 1, 1);
        tick(3);
        bus.gray_err_clr = 1'b1;
        push("clr_lose1", 1, M_ER, 0, 0, 0, 0, 1);
        push("clr_lose2", 2, M_ER, 0, 0, 0, 0, 1);
        tick(3);
        bus.gray_err_clr = 1'b0;
        bus.wptr = 9'd1;
        push("sticky", 1, M_WF | M_AF | M_ER, 0, 0, 256, 0, 1);
        tick(2);

        // Reset mid-traffic, then warm-up with a far-off read pointer.
        wrst_n = 1'b0;
        push("rst_mid", 0, M_ALL, 0, 0, 256, 0, 0);
        bus.rptr_gray_async = 9'h0FF;
        bus.wptr = 9'h0AF;
        tick(2);
        wrst_n = 1'b1;
        push("wu1", 1, M_WG | M_WF | M_AF | M_ER, 'h0F8, 0, 81, 0, 0);
        push("wu2", 2, M_ER, 0, 0, 0, 0, 0);
        push("wu3", 3, M_RS | M_ER, 0, 'h0AA, 0, 0, 0);
        push("wu4", 4, M_WF | M_ER, 0, 0, 251, 0, 0);
        push("wu5", 5, M_ER, 0, 0, 0, 0, 0);
        push("wu6", 6, M_ER, 0, 0, 0, 0, 0);
        tick(7);

        // Pointer wrap: wptr 0x005 against read pointer 0x1FE.
        wrst_n = 1'b0;
        push("rst_wrap", 0, M_ALL, 0, 0, 256, 0, 0);
        bus.rptr_gray_async = 9'h101;
        bus.wptr = 9'h005;
        tick(2);
        wrst_n = 1'b1;
        push("wrap1", 1, M_WG | M_WF | M_ER, 7, 0, 251, 0, 0);
        push("wrap3", 3, M_RS, 0, 'h1FE, 0, 0, 0);
        push("wrap4", 4, M_WF | M_AF | M_ER, 0, 0, 249, 0, 0);
        push("wrap6", 6, M_ER, 0, 0, 0, 0, 0);
        tick(8);

        while (q.size() > 0) begin
            cur = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s.drain: got unchecked entry, required check at cycle %0d", cur.name, cur.due);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
